// File: rtl/tx_arbiter_pkg.sv
// Shared constants for the AVR transmit path: arbiter FSM encodings, AVR byte
// constants used by the message sources, and the round-robin pointer wrap helper.
package tx_arbiter_pkg;

    typedef logic [1:0] txa_state_t;

    localparam logic [1:0] TXA_IDLE = 2'd0;
    localparam logic [1:0] TXA_SEND = 2'd1;
    localparam logic [1:0] TXA_GAP  = 2'd2;
    localparam logic [1:0] TXA_FIN  = 2'd3;

    localparam logic [7:0] AVR_CR    = 8'h0D;
    localparam logic [7:0] AVR_SPACE = 8'h20;

    // Pointer increment with an explicit wrap at n, so non-power-of-two counts work.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Message-source / AVR transmit bundle; master is the arbiter side, slave the
// sources plus AVR transmitter.
interface tx_arbiter_if #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned LEN_BITS = 5
);

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*LEN_BITS-1:0] req_len;
    logic [NUM_REQ*8-1:0]        req_data;
    logic [LEN_BITS-1:0]         msg_addr;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          done;
    logic                        tx_busy;
    logic [7:0]                  tx_data;
    logic                        new_tx_data;

    modport master (
        input  req,
        input  req_len,
        input  req_data,
        input  tx_busy,
        output msg_addr,
        output grant,
        output done,
        output tx_data,
        output new_tx_data
    );

    modport slave (
        output req,
        output req_len,
        output req_data,
        output tx_busy,
        input  msg_addr,
        input  grant,
        input  done,
        input  tx_data,
        input  new_tx_data
    );

endinterface

// File: rtl/tx_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// at NUM_REQ. Kept generic so other shared channels can reuse it.
module rr_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Shares the AVR USB transmit channel between NUM_REQ message sources, streaming
// one whole message per round-robin grant and pacing bytes against tx_busy.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned LEN_BITS   = 5,
    parameter int unsigned GAP_CYCLES = 1
) (
    input logic          clk,
    input logic          rst,
    tx_arbiter_if.master bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LEN_BITS-1:0] ONE_L    = LEN_BITS'(1);

    txa_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                send_c;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    logic [LEN_BITS-1:0] len_arr  [NUM_REQ];
    logic [7:0]          data_arr [NUM_REQ];
    logic [7:0]          tx_data_c;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign len_arr[g]  = bus.req_len[g*LEN_BITS +: LEN_BITS];
        assign data_arr[g] = bus.req_data[g*8 +: 8];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (rr_q),
        .winner (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state and datapath update; req is only looked at from IDLE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        len_d   = len_q;
        addr_d  = addr_q;
        rr_d    = rr_q;
        gap_d   = gap_q;
        send_c  = 1'b0;
        case (state_q)
            TXA_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                    len_d   = len_arr[pick_idx];
                    addr_d  = '0;
                    state_d = (len_arr[pick_idx] == '0) ? TXA_FIN : TXA_SEND;
                end
            end
            TXA_SEND: begin
                if (!bus.tx_busy) begin
                    send_c = 1'b1;
                    if (addr_q == len_q - ONE_L) begin
                        state_d = TXA_FIN;
                    end else begin
                        addr_d  = addr_q + ONE_L;
                        gap_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? TXA_SEND : TXA_GAP;
                    end
                end
            end
            TXA_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = TXA_SEND;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            TXA_FIN: begin
                grant_d = '0;
                addr_d  = '0;
                rr_d    = IDX_W'(rr_wrap_inc(32'(idx_q), NUM_REQ));
                state_d = TXA_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = TXA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TXA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            rr_q    <= '0;
            gap_q   <= '0;
        end else begin
            grant_q <= grant_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
        end
    end

    // The owner's byte is steered straight through; AND-OR mux keeps it 0 when idle.
    always_comb begin
        tx_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                tx_data_c = tx_data_c | data_arr[i];
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.msg_addr    = addr_q;
    assign bus.done        = (state_q == TXA_FIN) ? grant_q : '0;
    assign bus.new_tx_data = send_c;
    assign bus.tx_data     = tx_data_c;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: table of single-source messages, directed multi-cycle
// sequences, then random traffic against a transaction-level reference model.
module tb_tx_arbiter;
    import tx_arbiter_pkg::*;

    localparam int NUM_REQ  = 3;
    localparam int LEN_BITS = 5;
    localparam int GAP      = 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    tx_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_BITS(LEN_BITS)) bus ();

    tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .LEN_BITS   (LEN_BITS),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Source models: byte memories read combinationally at msg_addr.
    logic [7:0]          msg    [NUM_REQ][32];
    logic [LEN_BITS-1:0] len_tb [NUM_REQ];
    logic [NUM_REQ*8-1:0] rd_flat;

    always_comb begin
        rd_flat = '0;
        for (int s = 0; s < NUM_REQ; s++) rd_flat[s*8 +: 8] = msg[s][bus.msg_addr];
    end
    assign bus.req_data = rd_flat;
    assign bus.req_len  = {len_tb[2], len_tb[1], len_tb[0]};

    // Trace of every cycle for the directed sequences.
    logic [NUM_REQ-1:0] gr_log [int];
    int st_cyc[$], st_dat[$], st_gr[$], dn_cyc[$], dn_bits[$];

    always @(negedge clk) begin
        gr_log[cyc] = bus.grant;
        if (bus.new_tx_data) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(int'(bus.tx_data));
            st_gr.push_back(int'(bus.grant));
        end
        if (bus.done != '0) begin
            dn_cyc.push_back(cyc);
            dn_bits.push_back(int'(bus.done));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic clear_logs();
        st_cyc.delete(); st_dat.delete(); st_gr.delete();
        dn_cyc.delete(); dn_bits.delete();
    endtask

    task automatic load_msg(input int s, input int len, input int base);
        len_tb[s] = LEN_BITS'(len);
        for (int k = 0; k < 32; k++) msg[s][k] = (k == len - 1) ? AVR_CR : 8'(base + k);
    endtask

    function automatic int rr_pick(input int r, input int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = (p + i) % NUM_REQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Reference model: arbitration, byte pacing and done timing from the rules.
    bit model_en = 0;
    int m_active = 0, m_pend = 0, m_req = 0, m_ptr = 0, m_w = 0, m_len = 0;
    int m_k = 0, m_next = 0, m_done_c = -1, m_msgs = 0;
    int m_lens [NUM_REQ];
    bit done_evt [NUM_REQ];

    always @(negedge clk) begin
        int exp_st, exp_dn;
        if (model_en) begin
            if (m_active == 0) begin
                if (m_pend != 0) begin
                    m_w = rr_pick(m_req, m_ptr);
                    chk("rand_grant", int'(bus.grant), 1 << m_w);
                    m_active = 1; m_len = m_lens[m_w]; m_k = 0; m_next = cyc;
                    m_done_c = (m_len == 0) ? cyc : -1;
                    m_pend = 0;
                end else begin
                    chk("rand_idle", int'({bus.grant, bus.done, bus.new_tx_data}), 0);
                    m_req = int'(bus.req);
                    for (int s = 0; s < NUM_REQ; s++) m_lens[s] = int'(len_tb[s]);
                    m_pend = (bus.req != '0) ? 1 : 0;
                end
            end
            if (m_active != 0) begin
                chk("rand_owner", int'(bus.grant), 1 << m_w);
                exp_st = (m_k < m_len && cyc >= m_next && !bus.tx_busy) ? 1 : 0;
                chk("rand_strobe", int'(bus.new_tx_data), exp_st);
                if (exp_st != 0 && bus.new_tx_data) begin
                    chk("rand_data", int'(bus.tx_data), int'(msg[m_w][m_k]));
                    m_k++;
                    m_next = cyc + 1 + GAP;
                    if (m_k == m_len) m_done_c = cyc + 1;
                end
                exp_dn = (m_k == m_len && cyc == m_done_c) ? (1 << m_w) : 0;
                chk("rand_done", int'(bus.done), exp_dn);
                if (exp_dn != 0) begin
                    m_active = 0;
                    m_ptr = (m_w + 1) % NUM_REQ;
                    done_evt[m_w] = 1;
                    m_msgs++;
                end
            end
        end
    end

    task automatic new_msg(input int s);
        int r;
        r = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 6));
        len_tb[s] = LEN_BITS'(r);
        for (int k = 0; k < 32; k++) msg[s][k] = 8'($urandom);
    endtask

    typedef struct {
        int src;
        int len;
        int done_at;
    } row_t;

    row_t rows [6];

    initial begin
        int t0;
        rows[0] = '{0, 4, 8};
        rows[1] = '{1, 0, 1};
        rows[2] = '{2, 1, 2};
        rows[3] = '{1, 5, 10};
        rows[4] = '{0, 31, 62};
        rows[5] = '{2, 2, 4};

        rst = 1'b1;
        bus.req = '0;
        bus.tx_busy = 1'b0;
        for (int s = 0; s < NUM_REQ; s++) begin
            load_msg(s, 0, 8'h41);
            done_evt[s] = 0;
        end
        step(); step(); step();
        rst = 1'b0;
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_strobe", int'(bus.new_tx_data), 0);
        chk("rst_addr", int'(bus.msg_addr), 0);
        chk("rst_txdata", int'(bus.tx_data), 0);
        step();

        // Single-source messages, request held only for the arbitration cycle.
        for (int r = 0; r < 6; r++) begin
            load_msg(rows[r].src, rows[r].len, 8'h41);
            clear_logs();
            t0 = cyc;
            bus.req = NUM_REQ'(1 << rows[r].src);
            step();
            bus.req = '0;
            wait_to(t0 + rows[r].done_at + 3);
            chk("row_grant", int'(gr_log[t0 + 1]), 1 << rows[r].src);
            chk("row_release", int'(gr_log[t0 + rows[r].done_at + 1]), 0);
            chk("row_nstrobe", st_cyc.size(), rows[r].len);
            for (int k = 0; k < st_cyc.size(); k++) begin
                chk("row_strobe_cyc", st_cyc[k] - t0, (1 + GAP) * k + 1);
                chk("row_data", st_dat[k], (k == rows[r].len - 1) ? int'(AVR_CR) : 8'h41 + k);
            end
            chk("row_ndone", dn_cyc.size(), 1);
            if (dn_cyc.size() > 0) begin
                chk("row_done_cyc", dn_cyc[0] - t0, rows[r].done_at);
                chk("row_done_bits", dn_bits[0], 1 << rows[r].src);
            end
            step();
        end

        // Round-robin with every source requesting two-byte messages.
        for (int s = 0; s < NUM_REQ; s++) load_msg(s, 2, 8'h30 + 4 * s);
        clear_logs();
        t0 = cyc;
        bus.req = '1;
        for (int n = 0; n < 60 && dn_cyc.size() < 4; n++) step();
        bus.req = '0;
        step(); step(); step();
        chk("rr_ndone", dn_cyc.size(), 4);
        chk("rr_nstrobe", st_cyc.size(), 8);
        for (int m = 0; m < 4 && m < dn_cyc.size(); m++) begin
            chk("rr_done_bits", dn_bits[m], 1 << (m % NUM_REQ));
            chk("rr_done_cyc", dn_cyc[m] - t0, 4 + 5 * m);
        end
        for (int j = 0; j < 8 && j < st_cyc.size(); j++) begin
            chk("rr_data", st_dat[j], int'(msg[(j / 2) % NUM_REQ][j % 2]));
            chk("rr_strobe_grant", st_gr[j], 1 << ((j / 2) % NUM_REQ));
        end

        // Backpressure: tx_busy high for five cycles after the first byte.
        load_msg(0, 3, 8'h61);
        clear_logs();
        t0 = cyc;
        bus.req = 3'b001;
        step();
        bus.req = '0;
        step();
        bus.tx_busy = 1'b1;
        wait_to(t0 + 7);
        bus.tx_busy = 1'b0;
        wait_to(t0 + 13);
        chk("bp_nstrobe", st_cyc.size(), 3);
        for (int k = 0; k < 3 && k < st_cyc.size(); k++) begin
            chk("bp_strobe_cyc", st_cyc[k] - t0, (k == 0) ? 1 : 5 + 2 * k);
            chk("bp_data", st_dat[k], (k == 2) ? int'(AVR_CR) : 8'h61 + k);
        end
        chk("bp_ndone", dn_cyc.size(), 1);
        if (dn_cyc.size() > 0) chk("bp_done_cyc", dn_cyc[0] - t0, 10);

        // tx_busy already high when the grant lands.
        load_msg(1, 1, 8'h51);
        clear_logs();
        t0 = cyc;
        bus.req = 3'b010;
        bus.tx_busy = 1'b1;
        step();
        bus.req = '0;
        wait_to(t0 + 4);
        bus.tx_busy = 1'b0;
        wait_to(t0 + 8);
        chk("gb_hold_grant", int'(gr_log[t0 + 3]), 2);
        chk("gb_nstrobe", st_cyc.size(), 1);
        if (st_cyc.size() > 0) chk("gb_strobe_cyc", st_cyc[0] - t0, 4);
        chk("gb_ndone", dn_cyc.size(), 1);
        if (dn_cyc.size() > 0) chk("gb_done_cyc", dn_cyc[0] - t0, 5);

        // Source 0 drops req after byte 1; source 2 requests mid-message.
        load_msg(0, 5, 8'h70);
        load_msg(2, 1, 8'h20);
        clear_logs();
        t0 = cyc;
        bus.req = 3'b001;
        wait_to(t0 + 2);
        bus.req = '0;
        wait_to(t0 + 4);
        bus.req = 3'b100;
        wait_to(t0 + 12);
        bus.req = '0;
        wait_to(t0 + 16);
        chk("dl_nstrobe", st_cyc.size(), 6);
        for (int k = 0; k < 5 && k < st_cyc.size(); k++) begin
            chk("dl_strobe_cyc", st_cyc[k] - t0, 1 + 2 * k);
            chk("dl_data", st_dat[k], int'(msg[0][k]));
            chk("dl_strobe_grant", st_gr[k], 1);
        end
        if (st_cyc.size() > 5) begin
            chk("dl_late_cyc", st_cyc[5] - t0, 12);
            chk("dl_late_grant", st_gr[5], 4);
        end
        chk("dl_idle_gap", int'(gr_log[t0 + 11]), 0);
        chk("dl_ndone", dn_cyc.size(), 2);
        if (dn_cyc.size() > 1) begin
            chk("dl_done0", (dn_cyc[0] - t0) * 16 + dn_bits[0], 10 * 16 + 1);
            chk("dl_done2", (dn_cyc[1] - t0) * 16 + dn_bits[1], 13 * 16 + 4);
        end

        // Move the pointer off 0, then reset in the middle of source 1's message.
        load_msg(0, 0, 8'h41);
        bus.req = 3'b001;
        step();
        bus.req = '0;
        step(); step(); step();
        load_msg(0, 1, 8'h11);
        load_msg(1, 8, 8'h81);
        clear_logs();
        t0 = cyc;
        bus.req = 3'b011;
        wait_to(t0 + 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_grant", int'(bus.grant), 0);
        chk("mr_strobe", int'(bus.new_tx_data), 0);
        chk("mr_addr", int'(bus.msg_addr), 0);
        chk("mr_done", int'(bus.done), 0);
        wait_to(t0 + 7);
        bus.req = 3'b010;
        wait_to(t0 + 10);
        bus.req = '0;
        wait_to(t0 + 28);
        chk("mr_pre_grant", int'(gr_log[t0 + 1]), 2);
        chk("mr_ptr_grant", int'(gr_log[t0 + 7]), 1);
        chk("mr_idle", int'(gr_log[t0 + 9]), 0);
        chk("mr_regrant", int'(gr_log[t0 + 10]), 2);
        chk("mr_nstrobe", st_cyc.size(), 12);
        if (st_cyc.size() > 4) begin
            chk("mr_cut_cyc", st_cyc[2] - t0, 5);
            chk("mr_src0_cyc", st_cyc[3] - t0, 7);
            chk("mr_restart_cyc", st_cyc[4] - t0, 10);
            chk("mr_restart_data", st_dat[4], 8'h81);
        end
        chk("mr_ndone", dn_cyc.size(), 2);
        if (dn_cyc.size() > 1) begin
            chk("mr_done_a", (dn_cyc[0] - t0) * 16 + dn_bits[0], 8 * 16 + 1);
            chk("mr_done_b", (dn_cyc[1] - t0) * 16 + dn_bits[1], 25 * 16 + 2);
        end

        // Random traffic checked by the reference model from a clean reset.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        m_active = 0; m_pend = 0; m_ptr = 0; m_msgs = 0;
        model_en = 1;
        for (int n = 0; n < 4000; n++) begin
            step();
            bus.tx_busy = ($urandom_range(0, 9) < 3);
            for (int s = 0; s < NUM_REQ; s++) begin
                bit own;
                own = (m_active != 0) && (m_w == s);
                if (done_evt[s]) begin
                    done_evt[s] = 0;
                    if ($urandom_range(0, 1) == 0) bus.req[s] = 1'b0;
                    else new_msg(s);
                end else if (!bus.req[s] && !own) begin
                    if ($urandom_range(0, 3) == 0) begin
                        new_msg(s);
                        bus.req[s] = 1'b1;
                    end
                end else if (bus.req[s] && own && $urandom_range(0, 15) == 0) begin
                    bus.req[s] = 1'b0;
                end
            end
        end
        step();
        bus.req = '0;
        bus.tx_busy = 1'b0;
        for (int n = 0; n < 200 && (m_active != 0 || m_pend != 0); n++) step();
        step(); step();
        model_en = 0;
        chk("rand_quiesce", m_active + m_pend, 0);
        chk("rand_progress", (m_msgs >= 40) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
